// File: rtl/seq_det_arbiter.sv
// Two-requester front end for one shared serial pattern detector.
// Each requester's detector state is saved between its words, so its bits form one continuous stream.
module seq_det_arbiter #(
    parameter int         W       = 8,
    parameter logic [6:0] PATTERN = 7'b1111001,
    parameter int         CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [W-1:0]         req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [W-1:0]         req1_data,
    output logic                 req1_ready,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic                 hit,
    output logic                 hit_id,
    output logic [$clog2(W)-1:0] hit_pos,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);
    localparam int IW = $clog2(W);

    // Next prefix length after seeing bit b in state k: longest prefix of
    // PATTERN that is a suffix of (first k pattern bits followed by b).
    function automatic logic [2:0] kmp_next(input int k, input logic b);
        logic [7:0] s;
        logic       ok;
        logic [2:0] r;
        int         n;
        s = '0;
        for (int i = 0; i < 7; i++) begin
            if (i < k) s[i] = PATTERN[6-i];
        end
        s[k] = b;
        n    = k + 1;
        r    = '0;
        for (int len = 1; len <= 6; len++) begin
            if (len <= n) begin
                ok = 1'b1;
                for (int j = 0; j < 6; j++) begin
                    if (j < len) begin
                        if (s[n-len+j] != PATTERN[6-j]) ok = 1'b0;
                    end
                end
                if (ok) r = 3'(len);
            end
        end
        return r;
    endfunction

    function automatic logic [47:0] build_tab();
        logic [47:0] t;
        t = '0;
        for (int k = 0; k < 7; k++) begin
            t[(2*k)*3   +: 3] = kmp_next(k, 1'b0);
            t[(2*k+1)*3 +: 3] = kmp_next(k, 1'b1);
        end
        return t;
    endfunction

    localparam logic [47:0] NXT_TAB = build_tab();

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_nxt;
    logic          rr_ptr;
    logic          gnt;
    logic          accept;
    logic [W-1:0]  shreg;
    logic [2:0]    det, det_nxt;
    logic [2:0]    ctx0, ctx1;
    logic          id;
    logic [IW-1:0] idx;
    logic          cur_bit;
    logic          last_bit;
    logic          match;
    logic [5:0]    tab_base;

    // With both valid the pointer decides; otherwise the single valid one wins.
    always_comb begin
        gnt = req1_valid;
        if (req0_valid && req1_valid) gnt = rr_ptr;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !gnt;
    assign req1_ready = (state == IDLE) && req1_valid && gnt;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state == SHIFT);

    assign cur_bit  = shreg[W-1];
    assign last_bit = (idx == IW'(W - 1));
    assign tab_base = 6'({det, cur_bit}) * 6'd3;
    assign match    = (state == SHIFT) && (det == 3'd6) && (cur_bit == PATTERN[0]);
    assign det_nxt  = match ? 3'd0 : NXT_TAB[tab_base +: 3];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            shreg   <= '0;
            det     <= '0;
            ctx0    <= '0;
            ctx1    <= '0;
            id      <= 1'b0;
            idx     <= '0;
            hit     <= 1'b0;
            hit_id  <= 1'b0;
            hit_pos <= '0;
        end else begin
            hit <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    shreg  <= gnt ? req1_data : req0_data;
                    det    <= gnt ? ctx1 : ctx0;
                    id     <= gnt;
                    idx    <= '0;
                    rr_ptr <= ~gnt;
                end
            end else begin
                shreg <= {shreg[W-2:0], 1'b0};
                det   <= det_nxt;
                idx   <= idx + 1'b1;
                if (match) begin
                    hit     <= 1'b1;
                    hit_id  <= id;
                    hit_pos <= idx;
                end
                if (last_bit) begin
                    if (id) ctx1 <= det_nxt;
                    else    ctx0 <= det_nxt;
                end
            end
        end
    end

    // Clear wins over a same-cycle match; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (clr_cnt) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (match) begin
            if (!id && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
            if (id && cnt1 != '1)  cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Randomized and directed bench for seq_det_arbiter against a bit-window reference model.
module tb_seq_det_arbiter;
    localparam int         W       = 8;
    localparam int         CNT_W   = 2;
    localparam int         SAT     = 3;
    localparam logic [6:0] PATTERN = 7'b1111001;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         clr_cnt;
    logic         busy, hit, hit_id;
    logic [2:0]   hit_pos;
    logic [CNT_W-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    seq_det_arbiter #(.W(W), .PATTERN(PATTERN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr_cnt(clr_cnt), .busy(busy), .hit(hit), .hit_id(hit_id), .hit_pos(hit_pos),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: each requester keeps the bits seen since its last match;
    // a match is the last 7 of them equalling PATTERN.
    int           prio_m;
    logic [6:0]   hist_m [2];
    int           hlen_m [2];
    int           cnt_m  [2];
    logic         hit_m, id_m;
    logic [2:0]   pos_m;

    logic [W-1:0] q0[$], q1[$];
    logic [W-1:0] exp_q[$];
    logic [CNT_W-1:0] word_cnt[$];
    int           accepts, order_code, n_grants, hits_seen;
    bit           clr_rand;
    int           clr_word, clr_edge;

    function automatic logic [W-1:0] model_word(input int rid, input logic [W-1:0] w);
        logic [W-1:0] m;
        m = '0;
        for (int b = 0; b < W; b++) begin
            hist_m[rid] = {hist_m[rid][5:0], w[W-1-b]};
            hlen_m[rid]++;
            if (hlen_m[rid] >= 7 && hist_m[rid] == PATTERN) begin
                m[b]        = 1'b1;
                hlen_m[rid] = 0;
                hist_m[rid] = '0;
            end
        end
        return m;
    endfunction

    task automatic model_edge(input logic clr, input logic m, input int rid, input int pos);
        hit_m = m;
        if (m) begin
            id_m  = 1'(rid);
            pos_m = 3'(pos);
        end
        if (clr) begin
            cnt_m[0] = 0;
            cnt_m[1] = 0;
        end else if (m && cnt_m[rid] < SAT) begin
            cnt_m[rid]++;
        end
    endtask

    task automatic model_reset();
        prio_m = 0; hit_m = 1'b0; id_m = 1'b0; pos_m = '0;
        for (int i = 0; i < 2; i++) begin
            hist_m[i] = '0; hlen_m[i] = 0; cnt_m[i] = 0;
        end
        exp_q.delete(); word_cnt.delete();
        accepts = 0; order_code = 0; n_grants = 0; hits_seen = 0;
    endtask

    task automatic check_outputs(input string tag, input logic exp_busy);
        check({tag, "_busy"},   32'(busy),    32'(exp_busy));
        check({tag, "_hit"},    32'(hit),     32'(hit_m));
        check({tag, "_hit_id"}, 32'(hit_id),  32'(id_m));
        check({tag, "_hitpos"}, 32'(hit_pos), 32'(pos_m));
        check({tag, "_cnt0"},   32'(cnt0),    32'(cnt_m[0]));
        check({tag, "_cnt1"},   32'(cnt1),    32'(cnt_m[1]));
        if (hit) hits_seen++;
    endtask

    task automatic drive_valids();
        req0_valid = (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : W'($urandom);
        req1_valid = (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : W'($urandom);
    endtask

    task automatic pick_clr(input int c);
        clr_cnt = clr_rand ? ($urandom_range(0, 15) == 0) : 1'b0;
        if (c > 0 && accepts == clr_word && c == clr_edge) clr_cnt = 1'b1;
    endtask

    task automatic idle_cycle();
        logic clr_l;
        drive_valids();
        #1;
        check("gap_ready0", 32'(req0_ready), 0);
        check("gap_ready1", 32'(req1_ready), 0);
        pick_clr(0);
        clr_l = clr_cnt;
        @(posedge clk);
        model_edge(clr_l, 1'b0, 0, 0);
        @(negedge clk);
        check_outputs("gap", 1'b0);
        clr_cnt = 1'b0;
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic one_round();
        int           g;
        logic         clr_l;
        logic [W-1:0] w, mask;
        drive_valids();
        #1;
        if (req0_valid && req1_valid) g = prio_m;
        else if (req0_valid)          g = 0;
        else                          g = 1;
        check("ready0", 32'(req0_ready), 32'(g == 0));
        check("ready1", 32'(req1_ready), 32'(g == 1));
        check("idle_busy", 32'(busy), 0);
        pick_clr(0);
        clr_l = clr_cnt;
        @(posedge clk);
        w = (g == 1) ? q1.pop_front() : q0.pop_front();
        exp_q.push_back(model_word(g, w));
        prio_m = 1 - g;
        accepts++; n_grants++;
        order_code = order_code * 2 + g;
        model_edge(clr_l, 1'b0, 0, 0);
        @(negedge clk);
        check_outputs("e0", 1'b1);
        drive_valids();
        #1;
        check("busy_ready0", 32'(req0_ready), 0);
        check("busy_ready1", 32'(req1_ready), 0);
        mask = exp_q.pop_front();
        for (int c = 1; c <= W; c++) begin
            pick_clr(c);
            clr_l = clr_cnt;
            @(posedge clk);
            model_edge(clr_l, mask[c-1], g, c - 1);
            @(negedge clk);
            check_outputs("shift", c < W);
            if (c < W) begin
                check("shift_ready0", 32'(req0_ready), 0);
                check("shift_ready1", 32'(req1_ready), 0);
            end
        end
        word_cnt.push_back((g == 1) ? cnt1 : cnt0);
        clr_cnt = 1'b0;
    endtask

    task automatic run_rounds();
        int guard = 0;
        while ((q0.size() > 0 || q1.size() > 0) && guard < 400) begin
            guard++;
            one_round();
        end
        check("drain", 32'(q0.size() + q1.size()), 0);
    endtask

    task automatic do_reset();
        q0.delete(); q1.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        clr_cnt = 1'b0; clr_rand = 1'b0; clr_word = -1; clr_edge = -1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs("reset", 1'b0);
        check("reset_ready0", 32'(req0_ready), 0);
        check("reset_ready1", 32'(req1_ready), 0);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] gen_word();
        case ($urandom_range(0, 3))
            0:       return 8'hF2;
            1:       return {4'hF, 4'($urandom)};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        model_reset();

        // basic match
        do_reset();
        q0.push_back(8'hF2);
        run_rounds();
        check("basic_hits", 32'(hits_seen), 1);
        check("basic_pos", 32'(hit_pos), 6);
        check("basic_cnt0", 32'(cnt0), 1);
        check("basic_cnt1", 32'(cnt1), 0);

        // match spanning two words
        do_reset();
        q0.push_back(8'h0F); q0.push_back(8'h20);
        run_rounds();
        check("cross_hits", 32'(hits_seen), 1);
        check("cross_pos", 32'(hit_pos), 2);
        check("cross_cnt0", 32'(cnt0), 1);

        // per-requester contexts with alternating grants
        do_reset();
        q0.push_back(8'h0F); q0.push_back(8'h20); q1.push_back(8'h20);
        run_rounds();
        check("iso_grants", 32'(n_grants), 3);
        check("iso_order", 32'(order_code), 32'b010);
        check("iso_hits", 32'(hits_seen), 1);
        check("iso_hit_id", 32'(hit_id), 0);
        check("iso_pos", 32'(hit_pos), 2);
        check("iso_cnt0", 32'(cnt0), 1);
        check("iso_cnt1", 32'(cnt1), 0);

        // no overlapping matches
        do_reset();
        q0.push_back(8'hF3); q0.push_back(8'hC8);
        run_rounds();
        check("nonov_hits", 32'(hits_seen), 1);
        check("nonov_pos", 32'(hit_pos), 6);
        check("nonov_cnt0", 32'(cnt0), 1);

        // saturation, then clear on the fifth hit
        do_reset();
        clr_word = 5; clr_edge = 7;
        repeat (5) q1.push_back(8'hF2);
        run_rounds();
        check("sat_hits", 32'(hits_seen), 5);
        check("sat_cnt_w3", 32'(word_cnt[2]), 3);
        check("sat_cnt_w4", 32'(word_cnt[3]), 3);
        check("sat_cnt1_clr", 32'(cnt1), 0);
        clr_word = -1;

        // reset in the middle of a word
        do_reset();
        q0.push_back(8'hF2); q0.push_back(8'h0F);
        run_rounds();
        req0_valid = 1'b1; req0_data = 8'h20;
        #1;
        check("mid_ready0", 32'(req0_ready), 1);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 0);
        check("mid_hit", 32'(hit), 0);
        check("mid_hit_id", 32'(hit_id), 0);
        check("mid_hitpos", 32'(hit_pos), 0);
        check("mid_cnt0", 32'(cnt0), 0);
        check("mid_cnt1", 32'(cnt1), 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        q0.push_back(8'h20);
        run_rounds();
        check("mid_after_hits", 32'(hits_seen), 0);
        check("mid_after_cnt0", 32'(cnt0), 0);

        // randomized traffic
        do_reset();
        clr_rand = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) q0.push_back(gen_word());
            for (int i = 0; i < n1; i++) q1.push_back(gen_word());
            if (n0 + n1 == 0) idle_cycle();
            else              run_rounds();
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
